// File: rtl/eth_rx_led_monitor.sv
// MII receive monitor: preamble/SFD tracking, byte assembly, good/errored frame
// counters and a mode-selected LED display with activity/error stretchers.
module eth_rx_led_monitor #(
  parameter int LED_W       = 4,
  parameter int BYTE_IDX    = 14,
  parameter int STRETCH_CYC = 2500000
) (
  input  logic             eth_rx_clk,
  input  logic             rst,
  input  logic             eth_rx_dv,
  input  logic             eth_rx_er,
  input  logic [3:0]       eth_rxd,
  input  logic [1:0]       mode,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic             frame_done,
  output logic [LED_W-1:0] led
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam int             SW         = $clog2(STRETCH_CYC + 1);
  localparam logic [SW-1:0]  STRETCH_LD = SW'(STRETCH_CYC);
  localparam logic [7:0]     CAP_IDX    = 8'(BYTE_IDX);

  state_t        state_q;
  logic [1:0]    pre_cnt_q;
  logic          phase_q;
  logic [3:0]    low_nib_q;
  logic [7:0]    idx_q;
  logic          frm_err_q;
  logic [7:0]    rx_byte_q;
  logic          rx_byte_valid_q;
  logic          frame_done_q;
  logic [7:0]    cap_byte_q;
  logic [7:0]    good_cnt_q;
  logic [7:0]    err_cnt_q;
  logic [3:0]    last_nib_q;
  logic [SW-1:0] act_q, act_d;
  logic [SW-1:0] errs_q, errs_d;
  logic [LED_W-1:0] led_q, led_d;

  logic frame_end;
  logic frame_bad;

  // Handshake: rx_byte is meaningful only in the clock where rx_byte_valid is
  // high; there is no backpressure, every strobe must be consumed immediately.
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_done    = frame_done_q;
  assign led           = led_q;

  // A frame that ends on an odd nibble count is treated as errored.
  assign frame_end = (state_q == DATA) && !eth_rx_dv;
  assign frame_bad = frm_err_q | eth_rx_er | phase_q;

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pre_cnt_q       <= 2'd0;
      phase_q         <= 1'b0;
      low_nib_q       <= 4'd0;
      idx_q           <= 8'd0;
      frm_err_q       <= 1'b0;
      rx_byte_q       <= 8'd0;
      rx_byte_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      cap_byte_q      <= 8'd0;
      good_cnt_q      <= 8'd0;
      err_cnt_q       <= 8'd0;
      last_nib_q      <= 4'd0;
    end else begin
      rx_byte_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      if (eth_rx_dv) last_nib_q <= eth_rxd;
      case (state_q)
        IDLE: begin
          if (eth_rx_dv) begin
            if (eth_rxd == 4'h5) begin
              state_q   <= PRE;
              pre_cnt_q <= 2'd1;
            end else begin
              state_q <= DROP;
            end
          end
        end
        PRE: begin
          if (!eth_rx_dv) begin
            state_q <= IDLE;
          end else if (eth_rxd == 4'h5) begin
            if (pre_cnt_q != 2'd2) pre_cnt_q <= pre_cnt_q + 2'd1;
          end else if (eth_rxd == 4'hD && pre_cnt_q == 2'd2) begin
            state_q   <= DATA;
            phase_q   <= 1'b0;
            idx_q     <= 8'd0;
            frm_err_q <= 1'b0;
          end else begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (eth_rx_er) frm_err_q <= 1'b1;
          if (!eth_rx_dv) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            if (frame_bad) err_cnt_q  <= err_cnt_q + 8'd1;
            else           good_cnt_q <= good_cnt_q + 8'd1;
          end else if (!phase_q) begin
            low_nib_q <= eth_rxd;
            phase_q   <= 1'b1;
          end else begin
            rx_byte_q       <= {eth_rxd, low_nib_q};
            rx_byte_valid_q <= 1'b1;
            phase_q         <= 1'b0;
            if (idx_q == CAP_IDX) cap_byte_q <= {eth_rxd, low_nib_q};
            if (idx_q != 8'hFF)   idx_q      <= idx_q + 8'd1;
          end
        end
        default: begin
          if (!eth_rx_dv) state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    act_d  = (act_q  != '0) ? act_q  - SW'(1) : act_q;
    errs_d = (errs_q != '0) ? errs_q - SW'(1) : errs_q;
    if (frame_end && !frame_bad) act_d  = STRETCH_LD;
    if (frame_end &&  frame_bad) errs_d = STRETCH_LD;
  end

  // Legacy mode mirrors the live nibble and falls back to the last valid one.
  always_comb begin
    led_d = '0;
    case (mode)
      2'd0:    led_d[3:0] = eth_rx_dv ? eth_rxd : last_nib_q;
      2'd1:    led_d      = cap_byte_q[LED_W-1:0];
      2'd2:    led_d      = good_cnt_q[LED_W-1:0];
      default: begin
        led_d[0]   = (act_q != '0);
        led_d[1]   = (errs_q != '0);
        led_d[3:2] = err_cnt_q[1:0];
      end
    endcase
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      errs_q <= '0;
      led_q  <= '0;
    end else begin
      act_q  <= act_d;
      errs_q <= errs_d;
      led_q  <= led_d;
    end
  end

endmodule

// File: tb/tb_eth_rx_led_monitor.sv
// Randomized and directed bench for eth_rx_led_monitor, checked against a
// frame-level model that classifies whole nibble sequences.
module tb_eth_rx_led_monitor;

  localparam int LED_W       = 4;
  localparam int BYTE_IDX    = 1;
  localparam int STRETCH_CYC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dv  = 1'b0;
  logic             er  = 1'b0;
  logic [3:0]       rxd = 4'd0;
  logic [1:0]       mode = 2'd0;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             frame_done;
  logic [LED_W-1:0] led;

  eth_rx_led_monitor #(
    .LED_W(LED_W), .BYTE_IDX(BYTE_IDX), .STRETCH_CYC(STRETCH_CYC)
  ) dut (
    .eth_rx_clk(clk), .rst(rst), .eth_rx_dv(dv), .eth_rx_er(er),
    .eth_rxd(rxd), .mode(mode), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .frame_done(frame_done), .led(led)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [3:0] nib_q[$];
  logic       er_q[$];
  int         exp_good = 0;
  int         exp_err  = 0;
  int         exp_fd   = 0;
  int         seen_fd  = 0;
  logic [7:0] exp_cap  = 8'd0;
  logic [3:0] exp_last = 4'd0;
  logic [7:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for byte strobes and frame_done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) seen_fd++;
      if (rx_byte_valid) begin
        if (exp_q.size() == 0) begin
          check("rx_byte_extra", {24'd0, rx_byte}, 32'h100);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(mon_exp));
        end
      end
    end
  end

  task automatic add_nib(input logic [3:0] n, input logic e);
    nib_q.push_back(n);
    er_q.push_back(e);
  endtask

  task automatic add_pre(input int n5, input logic [3:0] sfd);
    for (int i = 0; i < n5; i++) add_nib(4'h5, 1'b0);
    add_nib(sfd, 1'b0);
  endtask

  task automatic add_byte(input logic [7:0] b);
    add_nib(b[3:0], 1'b0);
    add_nib(b[7:4], 1'b0);
  endtask

  // Whole-frame reference: leading 5s, then an SFD 0xD after at least two
  // of them opens the payload; anything else is a dropped frame.
  task automatic model_frame();
    int   n;
    int   i;
    int   nd;
    logic bad;
    logic [7:0] b;
    n = nib_q.size();
    i = 0;
    while (i < n && nib_q[i] == 4'h5) i++;
    if (i == 0 || i == n) return;
    if (nib_q[i] != 4'hD || i < 2) return;
    nd  = n - i - 1;
    bad = (nd % 2) != 0;
    for (int k = 0; k < nd; k++) if (er_q[i + 1 + k]) bad = 1'b1;
    for (int k = 0; k < nd / 2; k++) begin
      b = {nib_q[i + 2 + 2 * k], nib_q[i + 1 + 2 * k]};
      exp_q.push_back(b);
      if (k == BYTE_IDX) exp_cap = b;
    end
    exp_fd++;
    if (bad) exp_err  = (exp_err + 1) % 256;
    else     exp_good = (exp_good + 1) % 256;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv  = 1'b0;
      er  = 1'b0;
      rxd = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drive_nib(input logic [3:0] n, input logic e);
    @(negedge clk);
    dv       = 1'b1;
    rxd      = n;
    er       = e;
    exp_last = n;
  endtask

  task automatic run_frame(input int gap);
    model_frame();
    for (int k = 0; k < nib_q.size(); k++) drive_nib(nib_q[k], er_q[k]);
    idle(gap);
    nib_q.delete();
    er_q.delete();
  endtask

  task automatic stretch_count(output int act_n, output int err_n);
    act_n = 0;
    err_n = 0;
    repeat (24) begin
      @(negedge clk);
      dv = 1'b0;
      er = 1'b0;
      if (led[0]) act_n++;
      if (led[1]) err_n++;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_frame_done"}, 32'(seen_fd), 32'(exp_fd));
    set_mode(2'd0);
    check({tag, "_led_m0"}, 32'(led), {28'd0, exp_last});
    set_mode(2'd1);
    check({tag, "_led_m1"}, 32'(led), {28'd0, exp_cap[3:0]});
    set_mode(2'd2);
    check({tag, "_led_m2"}, 32'(led), 32'(exp_good % 16));
    set_mode(2'd3);
    check({tag, "_led_m3"}, 32'(led), 32'((exp_err % 4) * 4));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #5 rst = 1'b1;
    exp_good = 0;
    exp_err  = 0;
    exp_cap  = 8'd0;
    exp_last = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    int act_n;
    int err_n;
    int fd0;
    int kind;
    int nb;
    int ep;
    logic [7:0] b;

    // Reset values
    mode = 2'd2;
    repeat (3) @(negedge clk);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_valid", 32'(rx_byte_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    idle(3);

    // Reference frame: 7x55, D5, 12 A7 3C
    mode = 2'd3;
    add_pre(15, 4'hD);
    add_byte(8'h12); add_byte(8'hA7); add_byte(8'h3C);
    run_frame(0);
    stretch_count(act_n, err_n);
    check("good_act_stretch", 32'(act_n), 32'(STRETCH_CYC));
    check("good_err_stretch", 32'(err_n), 32'd0);
    check_state("ref_good");
    set_mode(2'd1);
    check("ref_cap_led", 32'(led), 32'h7);
    set_mode(2'd2);
    check("ref_good_cnt", 32'(led), 32'h1);

    // Same frame with one errored nibble
    do_reset();
    mode = 2'd3;
    add_pre(15, 4'hD);
    add_byte(8'h12);
    add_nib(4'h7, 1'b1); add_nib(4'hA, 1'b0);
    add_byte(8'h3C);
    run_frame(0);
    stretch_count(act_n, err_n);
    check("err_err_stretch", 32'(err_n), 32'(STRETCH_CYC));
    check("err_act_stretch", 32'(act_n), 32'd0);
    check_state("ref_err");
    set_mode(2'd2);
    check("ref_err_good_cnt", 32'(led), 32'h0);
    set_mode(2'd3);
    check("ref_err_err_cnt", 32'(led), 32'h4);

    // Dropped sequences
    fd0 = seen_fd;
    add_nib(4'h5, 1'b0); add_nib(4'h5, 1'b0); add_nib(4'hA, 1'b0); run_frame(2);
    add_nib(4'h5, 1'b0); add_nib(4'hD, 1'b0); add_byte(8'h99); run_frame(2);
    add_nib(4'h3, 1'b0); add_pre(4, 4'hD); add_byte(8'h44); run_frame(2);
    add_pre(5, 4'h5); run_frame(12);
    check("drop_no_frame_done", 32'(seen_fd - fd0), 32'd0);
    check_state("drop");

    // Odd nibble count
    add_pre(7, 4'hD);
    add_byte(8'hC1); add_byte(8'h5E); add_nib(4'h9, 1'b0);
    run_frame(12);
    check_state("odd");
    check("odd_err_cnt", 32'(exp_err), 32'd2);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 5);
      nb   = $urandom_range(1, 10);
      if (kind <= 3) begin
        add_pre($urandom_range(2, 15), 4'hD);
        for (int k = 0; k < nb; k++) add_byte(8'($urandom_range(0, 255)));
        if (kind == 2) begin
          ep = $urandom_range(0, 2 * nb - 1);
          er_q[er_q.size() - 1 - ep] = 1'b1;
        end
        if (kind == 3) add_nib(4'($urandom_range(0, 15)), 1'b0);
      end else begin
        add_pre($urandom_range(0, 6), 4'($urandom_range(0, 15)));
        for (int k = 0; k < 2 * nb; k++)
          add_nib(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
      end
      run_frame($urandom_range(10, 14));
      check_state("rand");
    end

    // 256 back-to-back good frames with a one-clock gap
    do_reset();
    fd0 = seen_fd;
    for (int f = 0; f < 256; f++) begin
      add_pre(2, 4'hD);
      add_byte(8'($urandom_range(0, 255)));
      run_frame(1);
    end
    idle(12);
    check("wrap_frames", 32'(seen_fd - fd0), 32'd256);
    set_mode(2'd2);
    check("wrap_good_led", 32'(led), 32'h0);
    check_state("wrap");

    // Reset in the middle of byte 1
    do_reset();
    mode = 2'd2;
    drive_nib(4'h5, 1'b0); drive_nib(4'h5, 1'b0);
    drive_nib(4'h5, 1'b0); drive_nib(4'hD, 1'b0);
    exp_q.push_back(8'h12);
    drive_nib(4'h2, 1'b0); drive_nib(4'h1, 1'b0);
    drive_nib(4'h7, 1'b0);
    #5 rst = 1'b1;
    exp_good = 0;
    exp_err  = 0;
    exp_cap  = 8'd0;
    drive_nib(4'hA, 1'b0);
    check("midrst_rx_byte", 32'(rx_byte), 32'd0);
    check("midrst_valid", 32'(rx_byte_valid), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_led", 32'(led), 32'd0);
    drive_nib(4'h5, 1'b0);
    @(negedge clk);
    dv  = 1'b0;
    rst = 1'b0;
    exp_last = 4'd0;
    idle(3);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    check("midrst_good_led", 32'(led), 32'd0);
    add_pre(6, 4'hD);
    add_byte(8'h5A); add_byte(8'hB3);
    run_frame(12);
    check_state("post_rst");
    set_mode(2'd2);
    check("post_rst_good_cnt", 32'(led), 32'h1);

    idle(4);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_led_monitor.md
ETH_RX_LED_MONITOR -- requirements
Module: eth_rx_led_monitor

Interface
REQ-001 The module SHALL have parameter LED_W, default 4, which is the LED count (legal values 4..8).
REQ-002 The module SHALL have parameter BYTE_IDX, default 14, which is the post-SFD byte offset captured for display.
REQ-003 The module SHALL have parameter STRETCH_CYC, default 2500000, which is the activity/error LED hold time in clocks (minimum 1).
REQ-004 The module SHALL have port eth_rx_clk, input, 1 bit: the MII receive clock (25 MHz) and the only clock.
REQ-005 The module SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 The module SHALL have port eth_rx_dv, input, 1 bit: MII receive data valid.
REQ-007 The module SHALL have port eth_rx_er, input, 1 bit: MII receive error.
REQ-008 The module SHALL have port eth_rxd, input, 4 bits: MII receive nibble.
REQ-009 The module SHALL have port mode, input, 2 bits: display select, sampled every clock.
REQ-010 The module SHALL have port rx_byte, output, 8 bits: the assembled frame byte.
REQ-011 The module SHALL have port rx_byte_valid, output, 1 bit: a one-clock strobe qualifying rx_byte.
REQ-012 The module SHALL have port frame_done, output, 1 bit: a one-clock strobe at the end of each counted frame.
REQ-013 The module SHALL have port led, output, LED_W bits: the registered display output.

Function
REQ-014 All inputs SHALL be sampled on the posedge of eth_rx_clk; all outputs SHALL be registered.
REQ-015 The FSM SHALL have four states: IDLE, PRE, DATA and DROP.
REQ-016 IDLE: on dv=1 with rxd=0x5, the FSM SHALL go to PRE; on dv=1 with any other nibble, it SHALL go to DROP.
REQ-017 PRE: on rxd=0x5, the FSM SHALL stay in PRE.
REQ-018 PRE: on rxd=0xD with at least 2 consecutive 0x5 nibbles seen, the FSM SHALL go to DATA; an 0xD after fewer than 2 SHALL send it to DROP.
REQ-019 PRE: any other nibble SHALL send the FSM to DROP, and dv=0 SHALL send it to IDLE with nothing counted.
REQ-020 DATA: the block SHALL assemble bytes low nibble first; on the second nibble, rx_byte={2nd,1st} with rx_byte_valid high in the next clock (1-clock latency).
REQ-021 DATA: the byte index SHALL start at 0 after the SFD and saturate at 255 (no wrap).
REQ-022 The byte whose index equals BYTE_IDX SHALL be latched into cap_byte; frames shorter than BYTE_IDX+1 bytes SHALL leave cap_byte unchanged.
REQ-023 eth_rx_er=1 in any DATA cycle SHALL mark the frame errored.
REQ-024 DATA with dv=0 SHALL end the frame and return the FSM to IDLE, with frame_done high in the next clock.
REQ-025 At frame end, an odd nibble count SHALL discard the partial nibble and mark the frame errored.
REQ-026 At frame end, a clean frame SHALL increment good_cnt (8-bit, wraps 255->0); an errored frame SHALL increment err_cnt (8-bit, wraps) and SHALL NOT increment good_cnt.
REQ-027 DROP SHALL ignore data and return the FSM to IDLE on dv=0; no frame_done and no count changes SHALL occur.
REQ-028 A dv low for a single clock SHALL be sufficient to separate frames; the next frame starts from IDLE.
REQ-029 The activity stretcher SHALL load STRETCH_CYC on each frame_done of a good frame and decrement to 0 (reload on retrigger); act = count != 0.
REQ-030 The error stretcher SHALL behave identically, triggered by errored frames; err = count != 0.
REQ-031 In mode 0 (legacy), led[3:0] SHALL take rxd on every clock where dv=1, hold otherwise, and bits above 3 SHALL be 0.
REQ-032 In mode 1, led SHALL equal cap_byte[LED_W-1:0].
REQ-033 In mode 2, led SHALL equal good_cnt[LED_W-1:0].
REQ-034 In mode 3, led[0]=act, led[1]=err, led[3:2]=err_cnt[1:0], and the remaining bits SHALL be 0.
REQ-035 A mode change SHALL take effect on led 1 clock later; the underlying state SHALL be unaffected by mode.

Reset
REQ-036 On rst=1 (asynchronous), state SHALL be IDLE, and led, rx_byte, rx_byte_valid, frame_done, cap_byte, good_cnt, err_cnt, both stretchers, the nibble phase and the byte index SHALL all be 0.
REQ-037 A reset mid-frame SHALL abandon the frame with no count change; after release, reception SHALL restart only at the next preamble.
REQ-038 Release SHALL be treated as asynchronous; the first active edge after release behaves as IDLE.

Verification
REQ-039 Mode 1, BYTE_IDX=1: send 7x"55", "D5", bytes 0x12,0xA7,0x3C -> rx_byte_valid strobes 3 times with values 12,A7,3C; led=0x7 (LED_W=4); good_cnt=1; frame_done pulses once.
REQ-040 Same frame with eth_rx_er high on 1 data nibble -> err_cnt=1, good_cnt=0; mode 3 shows led[1]=1 for STRETCH_CYC=8 clocks, then 0.
REQ-041 Nibbles 5,5,A, then dv low; also 5,D -> DROP, no frame_done, counters unchanged.
REQ-042 Frame with 5 data nibbles -> 2 bytes strobed, err_cnt increments, 5th nibble discarded.
REQ-043 256 good frames, mode 2 -> good_cnt wraps to 0, led=0; frames separated by 1 idle clock are all counted.
REQ-044 Assert rst during byte 1 of a frame, release, send a good frame -> exactly one good_cnt increment and all outputs 0 during reset.
